// File: rtl/priority_encoder.sv
// priority_encoder: combinational priority encoder.
//   Picks the highest-priority set bit of input_unencoded. When LSB_HIGH_PRIORITY
//   is nonzero, bit 0 wins; otherwise bit WIDTH-1 wins.
// Ports:
//   input_unencoded  [WIDTH-1:0]          request vector
//   output_valid                          any bit set
//   output_encoded   [$clog2(WIDTH)-1:0]  index of the winning bit (0 when none)
//   output_unencoded [WIDTH-1:0]          one-hot of the winning bit (0 when none)
module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded,
  output logic [WIDTH-1:0]         output_unencoded
);

  localparam int ENC_W = $clog2(WIDTH);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    output_valid     = |input_unencoded;
    output_encoded   = '0;
    output_unencoded = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (input_unencoded[i]) begin
          output_encoded      = ENC_W'(i);
          output_unencoded    = '0;
          output_unencoded[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (input_unencoded[i]) begin
          output_encoded      = ENC_W'(i);
          output_unencoded    = '0;
          output_unencoded[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arbiter.sv
// arbiter: registered N-port arbiter, fixed-priority or round-robin, with optional
//   grant blocking (released by acknowledge or by request deassertion).
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   request        [PORTS-1:0]          per-port request level
//   acknowledge    [PORTS-1:0]          per-port release pulse (block + ack mode only)
//   grant          [PORTS-1:0]          registered one-hot grant, or zero
//   grant_valid                         registered OR of grant
//   grant_encoded  [$clog2(PORTS)-1:0]  registered index of the granted port
module arbiter #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int ENC_W = $clog2(PORTS);

  logic [PORTS-1:0] mask;

  logic             req_valid;
  logic [ENC_W-1:0] req_enc;
  logic [PORTS-1:0] req_onehot;
  logic             msk_valid;
  logic [ENC_W-1:0] msk_enc;
  logic [PORTS-1:0] msk_onehot;

  logic [PORTS-1:0] grant_next;
  logic             grant_valid_next;
  logic [ENC_W-1:0] grant_encoded_next;
  logic [PORTS-1:0] mask_next;
  logic             hold;

  // Round-robin mask covers only the ports that rank below the one just granted,
  // so the granted port drops to lowest priority at the next arbitration.
  function automatic logic [PORTS-1:0] rr_mask(input logic [ENC_W-1:0] idx);
    logic [PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (ARB_LSB_HIGH_PRIORITY != 0) m[i] = (i > int'(idx));
      else                            m[i] = (i < int'(idx));
    end
    return m;
  endfunction

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_req_enc (
    .input_unencoded  (request),
    .output_valid     (req_valid),
    .output_encoded   (req_enc),
    .output_unencoded (req_onehot)
  );

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_msk_enc (
    .input_unencoded  (request & mask),
    .output_valid     (msk_valid),
    .output_encoded   (msk_enc),
    .output_unencoded (msk_onehot)
  );

  always_comb begin
    grant_next         = '0;
    grant_valid_next   = 1'b0;
    grant_encoded_next = '0;
    mask_next          = mask;
    hold               = 1'b0;

    // Acknowledge bits of non-granted ports are masked off by the AND with grant.
    if (ARB_BLOCK != 0 && grant_valid) begin
      if (ARB_BLOCK_ACK != 0) hold = ~|(grant & acknowledge);
      else                    hold = |(grant & request);
    end

    if (hold) begin
      grant_next         = grant;
      grant_valid_next   = grant_valid;
      grant_encoded_next = grant_encoded;
    end else if (req_valid) begin
      if (ARB_TYPE_ROUND_ROBIN != 0 && msk_valid) begin
        grant_next         = msk_onehot;
        grant_encoded_next = msk_enc;
      end else begin
        grant_next         = req_onehot;
        grant_encoded_next = req_enc;
      end
      grant_valid_next = 1'b1;
      if (ARB_TYPE_ROUND_ROBIN != 0) mask_next = rr_mask(grant_encoded_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '1;
    end else begin
      grant         <= grant_next;
      grant_valid   <= grant_valid_next;
      grant_encoded <= grant_encoded_next;
      mask          <= mask_next;
    end
  end

endmodule
